// File: rtl/imem_sram.sv
// imem_sram: single-port SRAM behind valid/ready request/response channels with byte strobes,
// READ_LAT of 1 or 2, credit-based back-pressure and range checking; IMEM_PARITY_EN adds byte parity.
module imem_sram #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 512,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
`ifdef IMEM_PARITY_EN
  input  logic                err_inject,
`endif
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);
  localparam int NB = DATA_W / 8;
  localparam int QD = READ_LAT + 1;

  logic [1:0]        sync;
  logic [2:0]        cnt;
  logic [2:0]        q_cnt;
  logic [1:0]        wptr;
  logic [1:0]        rptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] q_data [4];
  logic [3:0]        q_err;
  logic              accept;
  logic              acc_rd;
  logic              acc_wr;
  logic              in_range;
  logic              pop;
  logic              push;
  logic              push_err;
  logic [DATA_W-1:0] push_data;
  logic              rd_err;
  logic [DATA_W-1:0] rd_data;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else sync <= {sync[0], 1'b1};

  // cnt covers reads in the pipeline plus queued responses, so the queue can never overflow
  assign req_ready = sync[1] & (cnt < 3'(QD));
  assign accept    = req_valid & req_ready;
  assign acc_rd    = accept & ~req_we;
  assign acc_wr    = accept & req_we;
  assign in_range  = 32'(req_addr) < DEPTH;
  assign rd_data   = in_range ? mem[req_addr] : '0;

  always_ff @(posedge clk)
    if (acc_wr && in_range)
      for (int i = 0; i < NB; i++)
        if (req_be[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];

`ifdef IMEM_PARITY_EN
  logic [NB-1:0] par [DEPTH];

  always_ff @(posedge clk)
    if (acc_wr && in_range)
      for (int i = 0; i < NB; i++)
        if (req_be[i]) par[req_addr][i] <= (^req_wdata[8*i +: 8]) ^ err_inject;

  always_comb begin
    rd_err = ~in_range;
    for (int i = 0; i < NB; i++)
      rd_err = rd_err | (in_range & (par[req_addr][i] != ^mem[req_addr][8*i +: 8]));
  end
`else
  assign rd_err = ~in_range;
`endif

  generate
    if (READ_LAT == 2) begin : g_stage
      logic              s_v;
      logic              s_e;
      logic [DATA_W-1:0] s_d;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          s_v <= 1'b0;
          s_e <= 1'b0;
          s_d <= '0;
        end else begin
          s_v <= acc_rd;
          s_e <= rd_err;
          s_d <= rd_data;
        end
      assign push      = s_v;
      assign push_err  = s_e;
      assign push_data = s_d;
    end else begin : g_direct
      assign push      = acc_rd;
      assign push_err  = rd_err;
      assign push_data = rd_data;
    end
  endgenerate

  assign rsp_valid = q_cnt != 3'd0;
  assign rsp_rdata = rsp_valid ? q_data[rptr] : '0;
  assign rsp_err   = rsp_valid & q_err[rptr];
  assign pop       = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      q_cnt <= '0;
      cnt   <= '0;
    end else begin
      if (push) wptr <= (wptr == 2'(QD-1)) ? 2'd0 : wptr + 2'd1;
      if (pop) rptr <= (rptr == 2'(QD-1)) ? 2'd0 : rptr + 2'd1;
      q_cnt <= q_cnt + {2'b0, push} - {2'b0, pop};
      cnt   <= cnt + {2'b0, acc_rd} - {2'b0, pop};
    end

  always_ff @(posedge clk)
    if (push) begin
      q_data[wptr] <= push_data;
      q_err[wptr]  <= push_err;
    end
endmodule
